// File: rtl/fb_scan_reader.sv
// Raster-order framebuffer scanner: one PLB single-beat read per pixel, each
// result pushed into the display FIFO as {line, col, color, pad}.
module fb_scan_reader #(
    parameter logic [10:0] FB_BASE_ADDR = 11'b1001_0000_000,
    parameter int          FIFO_LEN     = 96,
    parameter int          LINE_LEN     = 9,
    parameter int          COL_LEN      = 10,
    parameter int          NUM_LINES    = 480,
    parameter int          NUM_COLS     = 640,
    parameter int          C_MST_AWIDTH = 32,
    parameter int          C_MST_DWIDTH = 32
) (
    input  logic                        PLB_clk,
    input  logic                        reset_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_done,
    output logic [7:0]                  err_count,
    output logic [0:FIFO_LEN-1]         fifo_data,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    output logic                        IP2Bus_MstRd_Req,
    output logic                        IP2Bus_MstWr_Req,
    output logic [C_MST_AWIDTH-1:0]     IP2Bus_Mst_Addr,
    output logic [C_MST_DWIDTH/8-1:0]   IP2Bus_Mst_BE,
    output logic                        IP2Bus_Mst_Lock,
    output logic                        IP2Bus_Mst_Reset,
    output logic [C_MST_DWIDTH-1:0]     IP2Bus_MstWr_d,
    input  logic                        Bus2IP_Mst_CmdAck,
    input  logic                        Bus2IP_Mst_Cmplt,
    input  logic                        Bus2IP_Mst_Error,
    input  logic                        Bus2IP_Mst_Rearbitrate,
    input  logic                        Bus2IP_Mst_Cmd_Timeout,
    input  logic [C_MST_DWIDTH-1:0]     Bus2IP_MstRd_d,
    input  logic                        Bus2IP_MstRd_src_rdy_n,
    input  logic                        Bus2IP_MstWr_dst_rdy_n
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_PUSH} state_t;

    state_t                    state_q, state_d;
    logic [LINE_LEN-1:0]       line_q, line_d;
    logic [COL_LEN-1:0]        col_q, col_d;
    logic [C_MST_DWIDTH-1:0]   color_q, color_d;
    logic                      got_data_q, got_data_d;
    logic                      rd_req_q, rd_req_d;
    logic                      fifo_wr_en_q, fifo_wr_en_d;
    logic [0:FIFO_LEN-1]       fifo_data_q, fifo_data_d;
    logic                      busy_q, busy_d;
    logic                      frame_done_q, frame_done_d;
    logic [7:0]                err_count_q, err_count_d;
    logic                      beat_s;
    logic                      last_col_s;
    logic                      last_pix_s;
    logic                      unused_inputs_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    assign beat_s     = ~Bus2IP_MstRd_src_rdy_n;
    assign last_col_s = (col_q == COL_LEN'(NUM_COLS - 1));
    assign last_pix_s = last_col_s && (line_q == LINE_LEN'(NUM_LINES - 1));

    // Next-state and registered-output computation for the scan FSM
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        col_d        = col_q;
        color_d      = color_q;
        got_data_d   = got_data_q;
        rd_req_d     = rd_req_q;
        fifo_wr_en_d = 1'b0;
        fifo_data_d  = fifo_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_count_d  = err_count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    line_d   = '0;
                    col_d    = '0;
                    busy_d   = 1'b1;
                    rd_req_d = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // A rearbitrate drops the request for one cycle; the low cycle re-raises it.
                if (rd_req_q) begin
                    if (Bus2IP_Mst_CmdAck) begin
                        rd_req_d   = 1'b0;
                        got_data_d = 1'b0;
                        state_d    = S_DATA;
                    end else if (Bus2IP_Mst_Rearbitrate) begin
                        rd_req_d = 1'b0;
                    end else begin
                        rd_req_d = 1'b1;
                    end
                end else begin
                    rd_req_d = 1'b1;
                end
            end
            S_DATA: begin
                if (beat_s) begin
                    color_d    = Bus2IP_MstRd_d;
                    got_data_d = 1'b1;
                end else begin
                    got_data_d = got_data_q;
                end
                if (Bus2IP_Mst_Cmplt) begin
                    state_d = S_PUSH;
                    if (Bus2IP_Mst_Error || Bus2IP_Mst_Cmd_Timeout || !(got_data_q || beat_s)) begin
                        color_d     = '0;
                        err_count_d = sat_inc8(err_count_q);
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PUSH: begin
                if (!fifo_full) begin
                    fifo_wr_en_d = 1'b1;
                    fifo_data_d  = {16'(line_q), 16'(col_q), color_q, {(FIFO_LEN - 64){1'b0}}};
                    if (last_pix_s) begin
                        line_d       = '0;
                        col_d        = '0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        if (last_col_s) begin
                            col_d  = '0;
                            line_d = line_q + LINE_LEN'(1);
                        end else begin
                            col_d = col_q + COL_LEN'(1);
                        end
                        rd_req_d = 1'b1;
                        state_d  = S_REQ;
                    end
                end else begin
                    state_d = S_PUSH;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rd_req_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge PLB_clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            col_q        <= '0;
            color_q      <= '0;
            got_data_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            fifo_wr_en_q <= 1'b0;
            fifo_data_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_count_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            col_q        <= col_d;
            color_q      <= color_d;
            got_data_q   <= got_data_d;
            rd_req_q     <= rd_req_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_data_q  <= fifo_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_count_q  <= err_count_d;
        end
    end

    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign err_count        = err_count_q;
    assign fifo_data        = fifo_data_q;
    assign fifo_wr_en       = fifo_wr_en_q;
    assign IP2Bus_MstRd_Req = rd_req_q;
    assign IP2Bus_Mst_Addr  = {FB_BASE_ADDR, line_q, col_q, 2'b00};
    assign IP2Bus_MstWr_Req = 1'b0;
    assign IP2Bus_Mst_BE    = {(C_MST_DWIDTH / 8){1'b1}};
    assign IP2Bus_Mst_Lock  = 1'b0;
    assign IP2Bus_Mst_Reset = 1'b0;
    assign IP2Bus_MstWr_d   = {C_MST_DWIDTH{1'b0}};
    assign unused_inputs_s  = Bus2IP_MstWr_dst_rdy_n;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader on a 2x3 frame: a scripted PLB slave answers reads
// with data = address, and a pixel-index model predicts every request and push.
module tb_fb_scan_reader;
    localparam int NL    = 2;
    localparam int NC    = 3;
    localparam int TOTAL = NL * NC;

    logic        PLB_clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [7:0]  err_count;
    logic [0:95] fifo_data;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        IP2Bus_MstRd_Req;
    logic        IP2Bus_MstWr_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic [3:0]  IP2Bus_Mst_BE;
    logic        IP2Bus_Mst_Lock;
    logic        IP2Bus_Mst_Reset;
    logic [31:0] IP2Bus_MstWr_d;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;
    logic        Bus2IP_Mst_Rearbitrate;
    logic        Bus2IP_Mst_Cmd_Timeout;
    logic [31:0] Bus2IP_MstRd_d;
    logic        Bus2IP_MstRd_src_rdy_n;
    logic        Bus2IP_MstWr_dst_rdy_n;

    always #5 PLB_clk = ~PLB_clk;

    fb_scan_reader #(.NUM_LINES(NL), .NUM_COLS(NC)) dut (
        .PLB_clk(PLB_clk), .reset_n(reset_n), .start(start), .busy(busy),
        .frame_done(frame_done), .err_count(err_count), .fifo_data(fifo_data),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req),
        .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr), .IP2Bus_Mst_BE(IP2Bus_Mst_BE),
        .IP2Bus_Mst_Lock(IP2Bus_Mst_Lock), .IP2Bus_Mst_Reset(IP2Bus_Mst_Reset),
        .IP2Bus_MstWr_d(IP2Bus_MstWr_d), .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck),
        .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt), .Bus2IP_Mst_Error(Bus2IP_Mst_Error),
        .Bus2IP_Mst_Rearbitrate(Bus2IP_Mst_Rearbitrate),
        .Bus2IP_Mst_Cmd_Timeout(Bus2IP_Mst_Cmd_Timeout),
        .Bus2IP_MstRd_d(Bus2IP_MstRd_d), .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
        .Bus2IP_MstWr_dst_rdy_n(Bus2IP_MstWr_dst_rdy_n)
    );

    int checks = 0;
    int errors = 0;

    // Scenario knobs, written only by the stimulus thread while the DUT is idle
    int err_pixel    = -1;
    int nodata_pixel = -1;
    int rearb_pixel  = -1;
    bit rand_mode    = 1'b0;

    // Slave bookkeeping, written only by the slave thread
    int          ack_cnt   = 0;
    int          rearb_cnt = 0;
    logic [31:0] acked[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pix_addr(input int p);
        return 32'h9000_0000 | (32'(p / NC) << 12) | (32'(p % NC) << 2);
    endfunction

    function automatic logic [95:0] pix_word(input int p, input logic [31:0] color);
        return {16'(p / NC), 16'(p % NC), color, 32'h0};
    endfunction

    // PLB slave: acks immediately, returns data=addr with Cmplt on the next cycle
    initial begin
        logic [31:0] lat_addr;
        bit          pending;
        bit          rearb_used;
        bit          rearb_watch;
        int          low_cnt;
        int          cur_pix;
        pending = 1'b0; rearb_used = 1'b0; rearb_watch = 1'b0; low_cnt = 0; cur_pix = 0;
        lat_addr = 32'h0;
        forever begin
            @(negedge PLB_clk);
            Bus2IP_Mst_CmdAck = 1'b0;      Bus2IP_Mst_Cmplt = 1'b0;
            Bus2IP_Mst_Error = 1'b0;       Bus2IP_Mst_Rearbitrate = 1'b0;
            Bus2IP_Mst_Cmd_Timeout = 1'b0; Bus2IP_MstRd_src_rdy_n = 1'b1;
            Bus2IP_MstRd_d = 32'h0;        Bus2IP_MstWr_dst_rdy_n = 1'b1;
            if (reset_n !== 1'b1) begin
                pending = 1'b0; ack_cnt = 0; rearb_used = 1'b0; rearb_watch = 1'b0;
                if (rand_mode) begin
                    Bus2IP_Mst_CmdAck      = 1'($urandom_range(0, 1));
                    Bus2IP_Mst_Cmplt       = 1'($urandom_range(0, 1));
                    Bus2IP_Mst_Error       = 1'($urandom_range(0, 1));
                    Bus2IP_Mst_Rearbitrate = 1'($urandom_range(0, 1));
                    Bus2IP_Mst_Cmd_Timeout = 1'($urandom_range(0, 1));
                    Bus2IP_MstRd_src_rdy_n = 1'($urandom_range(0, 1));
                    Bus2IP_MstWr_dst_rdy_n = 1'($urandom_range(0, 1));
                    Bus2IP_MstRd_d         = $urandom;
                end
            end else if (pending) begin
                pending          = 1'b0;
                Bus2IP_Mst_Cmplt = 1'b1;
                Bus2IP_MstRd_d   = lat_addr;
                if (cur_pix != nodata_pixel) Bus2IP_MstRd_src_rdy_n = 1'b0;
                if (cur_pix == err_pixel) Bus2IP_Mst_Error = 1'b1;
            end else if (IP2Bus_MstRd_Req) begin
                if (rearb_watch) begin
                    chk("rearb_low_cycles", 128'(low_cnt), 128'(1));
                    chk("rearb_readdr", 128'(IP2Bus_Mst_Addr), 128'(pix_addr(rearb_pixel)));
                    rearb_watch = 1'b0;
                end
                if (ack_cnt == rearb_pixel && !rearb_used) begin
                    Bus2IP_Mst_Rearbitrate = 1'b1;
                    rearb_used = 1'b1; rearb_watch = 1'b1; low_cnt = 0;
                    rearb_cnt++;
                end else begin
                    Bus2IP_Mst_CmdAck = 1'b1;
                    lat_addr = IP2Bus_Mst_Addr;
                    acked.push_back(IP2Bus_Mst_Addr);
                    cur_pix  = ack_cnt;
                    pending  = 1'b1;
                    ack_cnt  = (ack_cnt + 1) % TOTAL;
                    if (ack_cnt == 0) rearb_used = 1'b0;
                end
            end else if (rearb_watch) begin
                low_cnt++;
            end
        end
    end

    // Compare process: model predicts requests and pushes from the pixel index
    initial begin
        bit   seen_rst;
        bit   rst_e;
        bit   full_e;
        bit   bad;
        int   push_idx;
        int   model_err;
        seen_rst = 1'b0; push_idx = 0; model_err = 0;
        forever begin
            @(posedge PLB_clk);
            rst_e  = (reset_n !== 1'b1);
            full_e = fifo_full;
            #1;
            if (rst_e) begin
                seen_rst = 1'b1; push_idx = 0; model_err = 0;
                chk("rst_outputs", 128'({IP2Bus_MstRd_Req, fifo_wr_en, busy, frame_done, err_count, fifo_data}), 128'(0));
            end else if (seen_rst) begin
                chk("tied_outputs", 128'({IP2Bus_MstWr_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d, IP2Bus_Mst_BE}),
                    128'({1'b0, 1'b0, 1'b0, 32'h0, 4'hF}));
                if (IP2Bus_MstRd_Req) begin
                    chk("req_addr", 128'(IP2Bus_Mst_Addr), 128'(pix_addr(ack_cnt)));
                    chk("req_busy", 128'(busy), 128'(1));
                end
                if (fifo_wr_en) begin
                    chk("push_not_full", 128'(full_e), 128'(0));
                    bad = (push_idx == err_pixel) || (push_idx == nodata_pixel);
                    if (bad && model_err < 255) model_err++;
                    chk("push_data", 128'(fifo_data), 128'(pix_word(push_idx, bad ? 32'h0 : pix_addr(push_idx))));
                    chk("push_errcnt", 128'(err_count), 128'(model_err));
                    chk("push_frame_done", 128'(frame_done), 128'(push_idx == TOTAL - 1));
                    push_idx = (push_idx + 1) % TOTAL;
                end else if (frame_done) begin
                    chk("stray_frame_done", 128'(frame_done), 128'(0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge PLB_clk);
        #1;
    endtask

    task automatic start_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'(1));
    endtask

    task automatic wait_push(input int budget);
        int n = 0;
        do begin tick(); n++; end while (!fifo_wr_en && n < budget);
        if (!fifo_wr_en) chk("push_timeout", 128'(fifo_wr_en), 128'(1));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin tick(); n++; end while (!frame_done && n < budget);
        chk("frame_done_seen", 128'(frame_done), 128'(1));
        chk("done_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        logic [31:0] exp_addrs[6];
        logic [95:0] w0;
        logic [95:0] w1;
        int          base;
        int          n;
        exp_addrs[0] = 32'h9000_0000; exp_addrs[1] = 32'h9000_0004; exp_addrs[2] = 32'h9000_0008;
        exp_addrs[3] = 32'h9000_1000; exp_addrs[4] = 32'h9000_1004; exp_addrs[5] = 32'h9000_1008;
        w0 = 96'h0000_0000_9000_0000_0000_0000;
        w1 = 96'h0000_0001_9000_0004_0000_0000;

        // Reset held with random bus and control inputs
        reset_n = 1'b0; start = 1'b0; fifo_full = 1'b0; rand_mode = 1'b1;
        repeat (8) begin
            tick();
            start     = 1'($urandom_range(0, 1));
            fifo_full = 1'($urandom_range(0, 1));
        end
        start = 1'b0; fifo_full = 1'b0; rand_mode = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("idle_busy", 128'(busy), 128'(0));

        // Full scan with an ideal slave; a stray start mid-frame is ignored
        base = acked.size();
        start_scan();
        wait_push(50);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(100);
        for (int i = 0; i < 6; i++) chk("scan_addr", 128'(acked[base + i]), 128'(exp_addrs[i]));
        chk("scan_errcnt", 128'(err_count), 128'(0));

        // Back-pressure at pixel 1
        start_scan();
        wait_push(50);
        fifo_full = 1'b1;
        for (int h = 1; h <= 10; h++) begin
            tick();
            if (h >= 4) begin
                chk("hold_no_wren", 128'(fifo_wr_en), 128'(0));
                chk("hold_no_req", 128'(IP2Bus_MstRd_Req), 128'(0));
                chk("hold_data", 128'(fifo_data), 128'(w0));
            end
        end
        fifo_full = 1'b0;
        tick();
        chk("resume_wren", 128'(fifo_wr_en), 128'(1));
        chk("resume_data", 128'(fifo_data), 128'(w1));
        wait_done(100);

        // Error completion on pixel 2, then completion without data on pixel 3
        err_pixel = 2;
        start_scan();
        wait_done(100);
        err_pixel = -1;
        chk("err_count_1", 128'(err_count), 128'(1));
        nodata_pixel = 3;
        start_scan();
        wait_done(100);
        nodata_pixel = -1;
        chk("err_count_2", 128'(err_count), 128'(2));

        // Rearbitrate on the first request
        rearb_pixel = 0;
        start_scan();
        wait_done(100);
        rearb_pixel = -1;
        chk("rearb_seen", 128'(rearb_cnt), 128'(1));

        // Reset while pixel 4 is in its data phase, then a fresh scan
        start_scan();
        n = 0;
        while (ack_cnt != 5 && n < 100) begin tick(); n++; end
        chk("reach_pixel4", 128'(ack_cnt), 128'(5));
        reset_n = 1'b0;
        tick();
        chk("rst_req", 128'(IP2Bus_MstRd_Req), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        tick();
        reset_n = 1'b1;
        tick();
        start_scan();
        wait_done(100);
        chk("rescan_errcnt", 128'(err_count), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
